wb_slot_scheduler: RTL
======================

Name: wb_slot_scheduler

Overview:
- Shared writeback-slot scheduler for the issue queues that drive one common integer result bus.
- Each cycle every issue port presents its selected op's fixed execution latency; the block grants a subset such that no two granted ops write back in the same cycle.
- Owns the single non-pipelined divider: tracks its occupancy and exposes busy / next-cycle-writeback-taken status, which issue queues use to gate divide and single-cycle ops.

Parameters:
- NUM_REQ, 4, number of requesting issue ports
- MAX_LAT, 34, longest supported latency in cycles (reservation horizon)
- DIV_LAT, 33, divider latency; divider is non-pipelined
- LAT_W, $clog2(MAX_LAT+1), latency field width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- IN_reqValid  in  NUM_REQ  port i has an op ready to issue
- IN_reqLat  in  NUM_REQ x LAT_W  latency of port i's op, legal range 1..MAX_LAT
- IN_reqDiv  in  NUM_REQ  port i's op uses the divider
- IN_reqSqN  in  NUM_REQ x SqN  sequence number of port i's op
- IN_branch  in  BranchProv  flush; .taken and .sqN are used
- OUT_grant  out  NUM_REQ  combinational grant, same cycle
- OUT_wbTakenNext  out  1  writeback slot at t+1 already reserved
- OUT_divBusy  out  1  divider occupied; gate divide issue

Behaviour:
- State:
  - resv[MAX_LAT-1:0]: bit k set means the writeback at cycle t+1+k is reserved.
  - divCnt, 6 bits.
  - divSqN.
  - rrPtr, $clog2(NUM_REQ) bits.
- Reset (async, rst_n=0): resv=0, divCnt=0, rrPtr=0. OUT_grant=0, OUT_wbTakenNext=0, OUT_divBusy=0 while in reset. Reset mid-operation discards all reservations and any running divide.
- Grant evaluation is combinational. Visit ports in order rrPtr, rrPtr+1, ... (mod NUM_REQ). Port i is granted iff all of:
  - IN_reqValid[i] is set;
  - IN_reqLat[i] is in 1..MAX_LAT;
  - resv[L-1]=0;
  - no earlier-visited grant this cycle has the same L;
  - if IN_reqDiv[i]: divCnt==0, no other div already granted this cycle, and L==DIV_LAT;
  - IN_branch.taken=0.
- Latency 0 or above MAX_LAT: never granted. Debug assertion fires.
- Registered update each cycle:
  - resv' = (resv >> 1) | OR over granted L>=2 of (1 << (L-2)).
  - A granted L=1 op consumes slot t+1 only; it is checked this cycle and not stored.
- OUT_wbTakenNext = resv[0]: the slot one cycle ahead is owned by a long op, so single-cycle ops must not issue.
- rrPtr' = (index of last granted port in visit order)+1 mod NUM_REQ if any grant; otherwise unchanged.
- Divider:
  - On div grant: divCnt'=DIV_LAT-1, divSqN'=IN_reqSqN[i].
  - Otherwise divCnt decrements while nonzero.
  - OUT_divBusy = (divCnt!=0).
- Flush (IN_branch.taken):
  - All grants are suppressed that cycle.
  - If divCnt!=0 and $signed(divSqN - IN_branch.sqN) > 0, then divCnt'=0.
  - resv still shifts; reservations of squashed ops are kept (bubble only, conservative).
- Simultaneous events:
  - A div grant in the cycle divCnt reaches 1→0 is not possible; the grant needs divCnt==0 at evaluation.
  - Two ports with equal L: only the first in round-robin order is granted.
- Wrap-around: SqN comparisons are signed-difference, so they are wrap-safe.
- Arithmetic: all shifts are MAX_LAT bits wide; grant masks are formed at full width before the OR.

Decomposition:
- Package additions:
  - WB_MAX_LAT, DIV_LAT, MUL_LAT constants.
  - WbReq_t struct {valid, lat, isDiv, sqN}, so issue queues and this block share one definition.
- Sub-module: rr_conflict_arbiter. It implements the rotating visit with per-latency conflict masking (purely combinational) and is reusable for a future second result bus.
- Registers stay in wb_slot_scheduler.

Test Plan:
- Release rst_n; port0 requests L=3 → grant[0]=1. Next cycle resv[1]=1. Two cycles after the grant, OUT_wbTakenNext=1 for exactly one cycle.
- Ports 0 and 2 both request L=5, rrPtr=0 → only grant[0]. Next cycle, with rrPtr=1, port 2 retries L=5 → granted, since slot t+5 is free.
- Port1 div L=33 → grant; OUT_divBusy=1 for 32 cycles. A second div request during that window is denied. OUT_wbTakenNext=1 in the cycle before writeback.
- Div in flight with divSqN=20; IN_branch.taken with sqN=15 → OUT_divBusy=0 next cycle. Same test with branch sqN=25 → divider stays busy.
- Assert rst_n=0 asynchronously mid-divide, with resv nonzero → all outputs 0 immediately. After release, an L=1 request is granted.
- Any IN_branch.taken cycle with all four ports valid → OUT_grant=0. Cover a wrap case: SqN=0xFFF…F vs branch sqN=0x1.

Source files
------------

// File: rtl/wb_slot_scheduler_pkg.sv
// Shared definitions for the integer result-bus writeback scheduler.
//   WB_MAX_LAT / WB_DIV_LAT / WB_MUL_LAT : functional-unit latencies
//   SqN, BranchProv, WbReq_t             : types shared with the issue queues
package wb_slot_scheduler_pkg;

    localparam int unsigned WB_MAX_LAT = 34;
    localparam int unsigned WB_DIV_LAT = 33;
    localparam int unsigned WB_MUL_LAT = 3;
    localparam int unsigned WB_LAT_W   = $clog2(WB_MAX_LAT + 1);
    localparam int unsigned NUM_WB_REQ = 4;
    localparam int unsigned SQN_W      = 7;
    localparam int unsigned DIV_CNT_W  = 6;

    typedef logic [SQN_W-1:0] SqN;

    typedef struct packed {
        logic taken;
        SqN   sqN;
    } BranchProv;

    typedef struct packed {
        logic                valid;
        logic [WB_LAT_W-1:0] lat;
        logic                isDiv;
        SqN                  sqN;
    } WbReq_t;

    // True when a is strictly younger than b; wrap-safe via signed difference.
    function automatic logic sqn_younger(input SqN a, input SqN b);
        SqN diff;
        diff = a - b;
        return !diff[SQN_W-1] && (diff != '0);
    endfunction

endpackage

// File: rtl/wb_slot_scheduler_arbiter.sv
// rr_conflict_arbiter: rotating-priority grant with per-latency slot conflict masking.
//   rr_ptr     : first port visited
//   kill       : suppress all grants this cycle
//   req_*      : per-port valid / divider use / latency
//   resv       : bit k set = writeback at t+1+k already owned
//   div_free   : divider idle
//   grant_c    : per-port grant
//   claim_c    : bit L-1 set for every granted latency L
//   next_ptr_c : port after the last granted one, or rr_ptr if none granted
module rr_conflict_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned MAX_LAT = 34,
    parameter int unsigned DIV_LAT = 33,
    parameter int unsigned LAT_W   = $clog2(MAX_LAT + 1),
    parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [PTR_W-1:0]              rr_ptr,
    input  logic                          kill,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_div,
    input  logic [NUM_REQ-1:0][LAT_W-1:0] req_lat,
    input  logic [MAX_LAT-1:0]            resv,
    input  logic                          div_free,
    output logic [NUM_REQ-1:0]            grant_c,
    output logic [MAX_LAT-1:0]            claim_c,
    output logic [PTR_W-1:0]              next_ptr_c
);

    localparam int unsigned SLOT_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    // Visit ports in rotating order; an earlier grant claims its slot for later ports.
    always_comb begin
        int   idx;
        int   lat;
        logic ok;
        logic div_taken;

        grant_c    = '0;
        claim_c    = '0;
        next_ptr_c = rr_ptr;
        div_taken  = 1'b0;
        idx        = 0;
        lat        = 0;
        ok         = 1'b0;

        for (int j = 0; j < int'(NUM_REQ); j++) begin
            idx = (int'(rr_ptr) + j) % int'(NUM_REQ);
            lat = int'(req_lat[PTR_W'(idx)]);
            ok  = !kill && req_valid[PTR_W'(idx)] && (lat >= 1) && (lat <= int'(MAX_LAT));
            if (ok) begin
                ok = !(resv[SLOT_W'(lat - 1)] || claim_c[SLOT_W'(lat - 1)]);
            end
            if (ok && req_div[PTR_W'(idx)]) begin
                ok = div_free && !div_taken && (lat == int'(DIV_LAT));
            end
            if (ok) begin
                grant_c[PTR_W'(idx)]     = 1'b1;
                claim_c[SLOT_W'(lat - 1)] = 1'b1;
                next_ptr_c               = PTR_W'((idx + 1) % int'(NUM_REQ));
                if (req_div[PTR_W'(idx)]) begin
                    div_taken = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_slot_scheduler.sv
// Writeback-slot scheduler for the shared integer result bus; owns the divider.
//   IN_reqValid/Lat/Div/SqN : per-port selected op
//   IN_branch               : flush (taken, sqN)
//   OUT_grant               : same-cycle issue grant
//   OUT_wbTakenNext         : slot t+1 already owned by a long op
//   OUT_divBusy             : divider occupied
module wb_slot_scheduler
    import wb_slot_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_WB_REQ,
    parameter int unsigned MAX_LAT = WB_MAX_LAT,
    parameter int unsigned DIV_LAT = WB_DIV_LAT,
    parameter int unsigned LAT_W   = $clog2(MAX_LAT + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            IN_reqValid,
    input  logic [NUM_REQ-1:0][LAT_W-1:0] IN_reqLat,
    input  logic [NUM_REQ-1:0]            IN_reqDiv,
    input  logic [NUM_REQ-1:0][SQN_W-1:0] IN_reqSqN,
    input  BranchProv                     IN_branch,
    output logic [NUM_REQ-1:0]            OUT_grant,
    output logic                          OUT_wbTakenNext,
    output logic                          OUT_divBusy
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [MAX_LAT-1:0]   resv_q, resv_d;
    logic [DIV_CNT_W-1:0] div_cnt_q, div_cnt_d;
    SqN                   div_sqn_q, div_sqn_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0] grant_c;
    logic [MAX_LAT-1:0] claim_c;
    logic [PTR_W-1:0]   next_ptr_c;
    logic               kill_c;

    // Grants are forced low while reset is asserted as well as on a flush.
    assign kill_c = IN_branch.taken || !rst_n;

    rr_conflict_arbiter #(
        .NUM_REQ (NUM_REQ),
        .MAX_LAT (MAX_LAT),
        .DIV_LAT (DIV_LAT),
        .LAT_W   (LAT_W),
        .PTR_W   (PTR_W)
    ) u_arb (
        .rr_ptr     (rr_ptr_q),
        .kill       (kill_c),
        .req_valid  (IN_reqValid),
        .req_div    (IN_reqDiv),
        .req_lat    (IN_reqLat),
        .resv       (resv_q),
        .div_free   (div_cnt_q == '0),
        .grant_c    (grant_c),
        .claim_c    (claim_c),
        .next_ptr_c (next_ptr_c)
    );

    assign OUT_grant       = grant_c;
    assign OUT_wbTakenNext = resv_q[0];
    assign OUT_divBusy     = (div_cnt_q != '0);

    // Next state: claim bit L-1 shifted down lands at L-2; an L=1 claim falls off.
    always_comb begin
        resv_d    = (resv_q >> 1) | (claim_c >> 1);
        rr_ptr_d  = next_ptr_c;
        div_cnt_d = div_cnt_q;
        div_sqn_d = div_sqn_q;

        if (div_cnt_q != '0) begin
            div_cnt_d = div_cnt_q - 1'b1;
        end
        // Squash a divide younger than the mispredicted branch.
        if (IN_branch.taken && (div_cnt_q != '0) && sqn_younger(div_sqn_q, IN_branch.sqN)) begin
            div_cnt_d = '0;
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_c[i] && IN_reqDiv[i]) begin
                div_cnt_d = DIV_CNT_W'(DIV_LAT - 1);
                div_sqn_d = IN_reqSqN[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resv_q    <= '0;
            div_cnt_q <= '0;
            div_sqn_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            resv_q    <= resv_d;
            div_cnt_q <= div_cnt_d;
            div_sqn_q <= div_sqn_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

`ifndef SYNTHESIS
    // Issue queues must never present latency 0 or beyond the reservation horizon.
    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                assert (!IN_reqValid[i] || ((IN_reqLat[i] != '0) && (IN_reqLat[i] <= LAT_W'(MAX_LAT))))
                    else $error("illegal writeback latency on port %0d", i);
            end
        end
    end
`endif

endmodule
